instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Instruction fetch and sequencing stage sitting directly upstream of the 4-register 8-bit add/mul datapath. Holds a small loadable program memory, walks a program counter through it, and for each 8-bit instruction drives the datapath's instruction bus, opcode-decoder enable and register-write strobe. It replaces the manual DIP/switch stimulus with timed, repeatable execution. Opcode `10`, unused by the datapath, is claimed here as HALT.

## Interface
Parameters:
- `PROG_DEPTH`, 16: program memory words; power of two, 2..256.
- `SETTLE_CYCLES`, 4: cycles `exec_en` is held before the write strobe, covering multiplier settle time; range 1..15.

Ports:
- `clk`  in  1  single clock; all state on its rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `run`  in  1  start pulse; sampled in IDLE or HALTED.
- `load_we`  in  1  program write strobe.
- `load_addr`  in  $clog2(PROG_DEPTH)  program write address.
- `load_data`  in  8  program write data.
- `instruction`  out  8  to datapath: [7:6] opcode, [5:4] dest, [3:2] src a, [1:0] src b.
- `exec_en`  out  1  to datapath opcode-decoder enable.
- `wr_en`  out  1  to datapath destination-decoder enable (register write strobe).
- `pc`  out  $clog2(PROG_DEPTH)  address of the current instruction.
- `busy`  out  1  high in FETCH/EXEC/WRITE/NEXT (and PAUSE).
- `halted`  out  1  high in HALTED.

## Operation
- States: IDLE, FETCH, EXEC, WRITE, NEXT, HALTED (PAUSE only with STEP_EN).
- IDLE: `run`=1 → `pc`←0, FETCH.
- FETCH: synchronous memory read of `pc`; next cycle `instruction` register loads the word. If opcode=`10` → HALTED; else → EXEC with settle counter ←0.
- EXEC: `exec_en`=1; counter increments each cycle; at counter=SETTLE_CYCLES-1 → WRITE.
- WRITE: `exec_en`=1, `wr_en`=1 for exactly one cycle → NEXT.
- NEXT: `exec_en`=0; `pc`←`pc`+1. If `pc`=PROG_DEPTH-1 before increment → HALTED with `pc` left at PROG_DEPTH-1 (no wrap); else → FETCH.
- HALTED: `run`=1 → `pc`←0, FETCH. Outputs held.
- `instruction` stable from end of FETCH until the next FETCH completes; never changes while `exec_en`=1.
- Program load: `load_we` honoured only in IDLE or HALTED; ignored (no write) in all other states. A write to the current `pc` in HALTED is visible on the next run.
- Simultaneous `run` and `load_we` in IDLE: write occurs, FSM also starts; first FETCH reads the post-write contents.
- Reset (any time, including mid-EXEC/WRITE): immediately state←IDLE, `pc`←0, `instruction`←0, `exec_en`←0, `wr_en`←0, `busy`←0, `halted`←0, settle counter←0. Memory contents are not cleared.

## Timing
- Per non-halt instruction: 1 FETCH + SETTLE_CYCLES EXEC + 1 WRITE + 1 NEXT = SETTLE_CYCLES+3 cycles.
- `run` to first `exec_en` rise: 2 cycles (IDLE→FETCH, FETCH→EXEC).
- `exec_en` high for SETTLE_CYCLES+1 consecutive cycles per instruction; `wr_en` in the last of them.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `INSTR_SEQ_STEP_EN`: when defined, adds input port `step` (1 bit) and state PAUSE. NEXT goes to PAUSE instead of FETCH (HALT/end-of-program behaviour unchanged); PAUSE → FETCH on a cycle with `step`=1; `busy` stays 1 in PAUSE. `step` is level-sampled; a held `step` advances one instruction per SETTLE_CYCLES+4 cycles.
- Not defined: no `step` port, no PAUSE; free-running execution as above.

## Structure
- Shared package `cpu_pkg`: state enum, opcode constants `OP_ADD`=00, `OP_LDI`=01, `OP_HALT`=10, `OP_MUL`=11, instruction field slice positions.
- One sub-module: `prog_mem` (PROG_DEPTH×8, one write port, one synchronous read port). FSM, counter and PC in the top.

## Test plan
- Reset mid-EXEC of a MUL: assert `clear`=0 → same cycle `exec_en`=`wr_en`=0, `pc`=0, `instruction`=0x00, `halted`=0.
- Load {0x40 ADD r0←r0+r0, 0xC5 MUL r0←r1*r1, 0x80 HALT}, pulse `run`, SETTLE_CYCLES=4 → `wr_en` pulses at cycles 6 and 13 after `run`, `halted`=1 at cycle 16 with `pc`=2, `exec_en` never high for 0x80.
- Program of 16 ADDs with no HALT → 16 `wr_en` pulses, then `halted`=1, `pc`=15.
- `load_we` to address 1 with 0xFF while `busy`=1 → memory unchanged; same write while HALTED then `run` → 0xFF fetched at `pc`=1.
- With `INSTR_SEQ_STEP_EN`: program {0x40,0x40,0x80}, `run`, no `step` → one `wr_en`, FSM stays PAUSE with `pc`=1; one `step` pulse → second `wr_en`, PAUSE at `pc`=2.
- SETTLE_CYCLES=1: `exec_en` high exactly 2 cycles per instruction, instruction period 4 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, opcode
// encodings and the bit positions of the instruction fields.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WRITE,
        ST_NEXT,
        ST_HALTED,
        ST_PAUSE
    } seq_state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_LDI  = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    localparam int INSTR_OP_HI   = 7;
    localparam int INSTR_OP_LO   = 6;
    localparam int INSTR_DST_HI  = 5;
    localparam int INSTR_DST_LO  = 4;
    localparam int INSTR_SRCA_HI = 3;
    localparam int INSTR_SRCA_LO = 2;
    localparam int INSTR_SRCB_HI = 1;
    localparam int INSTR_SRCB_LO = 0;

    function automatic logic [1:0] instr_opcode(input logic [7:0] i_instr);
        return i_instr[INSTR_OP_HI:INSTR_OP_LO];
    endfunction

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program memory: DEPTH x 8, one write port, one registered read port.
// A same-cycle write to the read address is forwarded so reads see new data.
module prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/sequence stage driving the add/mul datapath from a loadable program.
// Optional single-step mode (step port, PAUSE state) under INSTR_SEQ_STEP_EN.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter  int PROG_DEPTH    = 16,
    parameter  int SETTLE_CYCLES = 4,
    localparam int AW            = $clog2(PROG_DEPTH)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          run,
`ifdef INSTR_SEQ_STEP_EN
    input  logic          step,
`endif
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data,
    output logic [7:0]    instruction,
    output logic          exec_en,
    output logic          wr_en,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    localparam logic [AW-1:0] PC_LAST  = AW'(PROG_DEPTH - 1);
    localparam logic [3:0]    CNT_LAST = 4'(SETTLE_CYCLES - 1);

    seq_state_t    r_state, w_state_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic [7:0]    r_instr, w_instr_nxt;
    logic          r_exec_en, r_wr_en, r_busy, r_halted;
    logic          w_mem_we;
    logic [7:0]    w_rdata;

    // Reading at the next PC every cycle means the word for a FETCH is already
    // in the read register when FETCH starts, so FETCH takes one cycle.
    prog_mem #(.DEPTH(PROG_DEPTH)) u_prog_mem (
        .i_clk   (clk),
        .i_we    (w_mem_we),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_raddr (w_pc_nxt),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_instr_nxt = r_instr;
        w_mem_we    = load_we && ((r_state == ST_IDLE) || (r_state == ST_HALTED));
        case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (run) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_instr_nxt = w_rdata;
                if (instr_opcode(w_rdata) == OP_HALT) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == CNT_LAST)
                    w_state_nxt = ST_WRITE;
            end
            ST_WRITE: w_state_nxt = ST_NEXT;
            ST_NEXT: begin
                if (r_pc == PC_LAST) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_pc_nxt = r_pc + 1'b1;
`ifdef INSTR_SEQ_STEP_EN
                    w_state_nxt = ST_PAUSE;
`else
                    w_state_nxt = ST_FETCH;
`endif
                end
            end
`ifdef INSTR_SEQ_STEP_EN
            ST_PAUSE: begin
                if (step)
                    w_state_nxt = ST_FETCH;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_instr   <= '0;
            r_exec_en <= 1'b0;
            r_wr_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_instr   <= w_instr_nxt;
            r_exec_en <= (w_state_nxt == ST_EXEC) || (w_state_nxt == ST_WRITE);
            r_wr_en   <= (w_state_nxt == ST_WRITE);
            r_busy    <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_HALTED);
            r_halted  <= (w_state_nxt == ST_HALTED);
        end
    end

    assign instruction = r_instr;
    assign exec_en     = r_exec_en;
    assign wr_en       = r_wr_en;
    assign pc          = r_pc;
    assign busy        = r_busy;
    assign halted      = r_halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: two instances (SETTLE_CYCLES 4 and 1);
// stimulus queues expected write/halt events, a negedge monitor checks them.
module tb_instr_sequencer;

    localparam int DEPTH = 16;
    localparam int S0    = 4;
    localparam int S1    = 1;
`ifdef INSTR_SEQ_STEP_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int PER0 = S0 + 3 + EXTRA;
    localparam int PER1 = S1 + 3 + EXTRA;

    typedef struct {
        bit halt;
        int pc;
        int instr;
        int cyc;
        int elen;
    } exp_t;

    logic       clk, clear;
    logic       run0, we0, step0, run1, we1, step1;
    logic [3:0] addr0, addr1, pc0, pc1;
    logic [7:0] data0, data1, instr0, instr1;
    logic       exec0, wr0, busy0, halt0, exec1, wr1, busy1, halt1;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   mark0 = 0;
    int   mark1 = 0;
    int   elen0 = 0;
    int   elen1 = 0;
    bit   ph0 = 0;
    bit   ph1 = 0;

    instr_sequencer #(.PROG_DEPTH(DEPTH), .SETTLE_CYCLES(S0)) u_dut0 (
        .clk(clk), .clear(clear), .run(run0),
`ifdef INSTR_SEQ_STEP_EN
        .step(step0),
`endif
        .load_we(we0), .load_addr(addr0), .load_data(data0),
        .instruction(instr0), .exec_en(exec0), .wr_en(wr0), .pc(pc0),
        .busy(busy0), .halted(halt0)
    );

    instr_sequencer #(.PROG_DEPTH(DEPTH), .SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .clear(clear), .run(run1),
`ifdef INSTR_SEQ_STEP_EN
        .step(step1),
`endif
        .load_we(we1), .load_addr(addr1), .load_data(data1),
        .instruction(instr1), .exec_en(exec1), .wr_en(wr1), .pc(pc1),
        .busy(busy1), .halted(halt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void cmp(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endfunction

    task automatic check_evt(input int d, input bit h, input int p, input int ins,
                             input int c, input int el);
        exp_t e;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL d%0d_unexpected halt=%0d pc=%0d cyc=%0d", d, h, p, c);
            return;
        end
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        cmp($sformatf("d%0d_kind", d), int'(h), int'(e.halt));
        cmp($sformatf("d%0d_pc", d), p, e.pc);
        cmp($sformatf("d%0d_instr", d), ins, e.instr);
        cmp($sformatf("d%0d_cycle", d), c, e.cyc);
        cmp($sformatf("d%0d_exec_len", d), el, e.elen);
    endtask

    // Monitor: every wr_en pulse and every halted rise is one scoreboard event.
    always @(negedge clk) begin
        elen0 = exec0 ? elen0 + 1 : 0;
        elen1 = exec1 ? elen1 + 1 : 0;
        if (clear) begin
            if (wr0) check_evt(0, 1'b0, int'(pc0), int'(instr0), cyc - mark0, elen0);
            if (halt0 && !ph0) check_evt(0, 1'b1, int'(pc0), int'(instr0), cyc - mark0, elen0);
            if (wr1) check_evt(1, 1'b0, int'(pc1), int'(instr1), cyc - mark1, elen1);
            if (halt1 && !ph1) check_evt(1, 1'b1, int'(pc1), int'(instr1), cyc - mark1, elen1);
        end
        ph0 = halt0;
        ph1 = halt1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input bit h, input int p, input int ins, input int c);
        exp_t e;
        e.halt  = h;
        e.pc    = p;
        e.instr = ins;
        e.cyc   = c;
        e.elen  = h ? 0 : ((d == 0) ? S0 : S1) + 1;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic load(input int d, input int a, input int v);
        if (d == 0) begin we0 = 1'b1; addr0 = 4'(a); data0 = 8'(v); end
        else        begin we1 = 1'b1; addr1 = 4'(a); data1 = 8'(v); end
        tick();
        we0 = 1'b0;
        we1 = 1'b0;
    endtask

    task automatic go(input int d);
        if (d == 0) begin run0 = 1'b1; mark0 = cyc; end
        else        begin run1 = 1'b1; mark1 = cyc; end
        tick();
        run0 = 1'b0;
        run1 = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout left0=%0d left1=%0d required=0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        repeat (2) tick();
    endtask

    initial begin
        clear = 1'b0;
        {run0, we0, run1, we1} = '0;
        step0 = (EXTRA != 0);
        step1 = (EXTRA != 0);
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        repeat (2) tick();

        cmp("rst_pc", int'(pc0), 0);
        cmp("rst_instr", int'(instr0), 0);
        cmp("rst_exec_en", int'(exec0), 0);
        cmp("rst_wr_en", int'(wr0), 0);
        cmp("rst_busy", int'(busy0), 0);
        cmp("rst_halted", int'(halt0), 0);
        clear = 1'b1;
        tick();

        // ADD, MUL, HALT
        load(0, 0, 8'h40); load(0, 1, 8'hC5); load(0, 2, 8'h80);
        push(0, 0, 0, 8'h40, S0 + 2);
        push(0, 0, 1, 8'hC5, PER0 + S0 + 2);
        push(0, 1, 2, 8'h80, 2 * PER0 + 2);
        go(0);
        drain(100);

        // Full memory of ADDs: ends by running off the last address.
        for (int i = 0; i < DEPTH; i++) load(0, i, 8'h40);
        for (int i = 0; i < DEPTH; i++) push(0, 0, i, 8'h40, i * PER0 + S0 + 2);
        push(0, 1, DEPTH - 1, 8'h40, (DEPTH - 1) * PER0 + S0 + 4);
        go(0);
        drain(400);

        // A load while busy must be dropped; the same load while halted lands.
        load(0, 2, 8'h80);
        push(0, 0, 0, 8'h40, S0 + 2);
        push(0, 0, 1, 8'h40, PER0 + S0 + 2);
        push(0, 1, 2, 8'h80, 2 * PER0 + 2);
        go(0);
        repeat (2) tick();
        cmp("busy_during_load", int'(busy0), 1);
        load(0, 1, 8'hFF);
        drain(100);
        load(0, 1, 8'hFF);
        push(0, 0, 0, 8'h40, S0 + 2);
        push(0, 0, 1, 8'hFF, PER0 + S0 + 2);
        push(0, 1, 2, 8'h80, 2 * PER0 + 2);
        go(0);
        drain(100);

        // Short settle time on the second instance.
        load(1, 0, 8'h40); load(1, 1, 8'h40); load(1, 2, 8'h80);
        push(1, 0, 0, 8'h40, S1 + 2);
        push(1, 0, 1, 8'h40, PER1 + S1 + 2);
        push(1, 1, 2, 8'h80, 2 * PER1 + 2);
        go(1);
        drain(100);

        // Asynchronous clear in the middle of the MUL at pc=1.
        load(0, 1, 8'hC5);
        push(0, 0, 0, 8'h40, S0 + 2);
        go(0);
        for (int n = 0; n < 50 && (cyc - mark0) < PER0 + 3; n++) tick();
        cmp("pre_clr_exec_en", int'(exec0), 1);
        cmp("pre_clr_instr", int'(instr0), 8'hC5);
        cmp("pre_clr_pc", int'(pc0), 1);
        clear = 1'b0;
        #1;
        cmp("clr_exec_en", int'(exec0), 0);
        cmp("clr_wr_en", int'(wr0), 0);
        cmp("clr_pc", int'(pc0), 0);
        cmp("clr_instr", int'(instr0), 0);
        cmp("clr_halted", int'(halt0), 0);
        cmp("clr_busy", int'(busy0), 0);
        cmp("q_empty_at_clr", q0.size(), 0);
        q0.delete();
        @(negedge clk);
        clear = 1'b1;
        tick();

        // run together with a write to address 0 from IDLE: fetch sees new word.
        we0 = 1'b1; addr0 = 4'd0; data0 = 8'h80; run0 = 1'b1; mark0 = cyc;
        push(0, 1, 0, 8'h80, 2);
        tick();
        we0 = 1'b0; run0 = 1'b0;
        drain(20);

`ifdef INSTR_SEQ_STEP_EN
        step0 = 1'b0;
        load(0, 0, 8'h40); load(0, 1, 8'h40); load(0, 2, 8'h80);
        push(0, 0, 0, 8'h40, S0 + 2);
        go(0);
        drain(50);
        repeat (6) tick();
        cmp("pause_pc1", int'(pc0), 1);
        cmp("pause_busy1", int'(busy0), 1);
        push(0, 0, 1, 8'h40, S0 + 2);
        step0 = 1'b1; mark0 = cyc;
        tick();
        step0 = 1'b0;
        drain(50);
        repeat (6) tick();
        cmp("pause_pc2", int'(pc0), 2);
        cmp("pause_busy2", int'(busy0), 1);
        push(0, 1, 2, 8'h80, 2);
        step0 = 1'b1; mark0 = cyc;
        tick();
        step0 = 1'b0;
        drain(50);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
